// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and default widths for the CPU run/step/halt sequencer.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_BRK  = 2'd3
    } run_state_t;

    localparam int unsigned PC_W_DEF   = 9;
    localparam int unsigned STEP_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 32;

endpackage

// File: rtl/cpu_run_ctrl_btn_edge_det.sv
// Rising-edge detector for a debounced button level; the previous level resets to 0,
// so a button already high when reset releases yields one request.
module btn_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic rise_o
);

    logic r_prev;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= level_i;
        end
    end

    assign rise_o = level_i & ~r_prev;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer producing the datapath enable, with a live PC breakpoint
// and a retired-instruction counter.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned PC_W   = PC_W_DEF,
    parameter int unsigned STEP_W = STEP_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
    input  logic              step_i,
    input  logic              halt_i,
    input  logic [STEP_W-1:0] step_n_i,
    input  logic              bp_en_i,
    input  logic [PC_W-1:0]   bp_addr_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              cnt_clr_i,
    output logic              en_o,
    output logic [1:0]        state_o,
    output logic              bp_hit_o,
    output logic [CNT_W-1:0]  retired_o
);

    run_state_t        r_state;
    run_state_t        w_state_nxt;
    logic [STEP_W-1:0] r_step_cnt;
    logic              r_skip_bp;
    logic [CNT_W-1:0]  r_retired;

    logic w_run_req;
    logic w_step_req;
    logic w_halt_req;
    logic w_active;
    logic w_idle;
    logic w_bp_match;
    logic w_en;
    logic w_launch;

    btn_edge_det u_run_edge  (.clk_i(clk_i), .rst_i(rst_i), .level_i(run_i),  .rise_o(w_run_req));
    btn_edge_det u_step_edge (.clk_i(clk_i), .rst_i(rst_i), .level_i(step_i), .rise_o(w_step_req));
    btn_edge_det u_halt_edge (.clk_i(clk_i), .rst_i(rst_i), .level_i(halt_i), .rise_o(w_halt_req));

    assign w_active   = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign w_idle     = ~w_active;
    assign w_bp_match = bp_en_i & (pc_i == bp_addr_i) & ~r_skip_bp;
    assign w_en       = w_active & ~w_bp_match & ~w_halt_req;
    assign w_launch   = w_idle & ~w_halt_req & (w_step_req | w_run_req);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_HALT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_HALT, ST_BRK: begin
                if (w_halt_req)      w_state_nxt = ST_HALT;
                else if (w_step_req) w_state_nxt = ST_STEP;
                else if (w_run_req)  w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_halt_req)      w_state_nxt = ST_HALT;
                else if (w_bp_match) w_state_nxt = ST_BRK;
            end
            ST_STEP: begin
                if (w_halt_req)                       w_state_nxt = ST_HALT;
                else if (w_bp_match)                  w_state_nxt = ST_BRK;
                else if (r_step_cnt == STEP_W'(1))    w_state_nxt = ST_HALT;
            end
            default: w_state_nxt = ST_HALT;
        endcase
    end

    always_comb begin
        en_o     = w_en;
        bp_hit_o = w_active & w_bp_match & ~w_halt_req;
        state_o  = r_state;
    end

    // skip_bp lets execution resume from the breakpoint PC: it masks the compare
    // until the first instruction after a launch has retired.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_step_cnt <= '0;
            r_skip_bp  <= 1'b0;
        end else begin
            if (w_launch && w_step_req) begin
                r_step_cnt <= (step_n_i == '0) ? STEP_W'(1) : step_n_i;
            end else if (r_state == ST_STEP && w_en) begin
                r_step_cnt <= r_step_cnt - STEP_W'(1);
            end else if (r_state == ST_STEP) begin
                r_step_cnt <= '0;
            end

            if (w_launch) begin
                r_skip_bp <= 1'b1;
            end else if (w_en || w_halt_req) begin
                r_skip_bp <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_retired <= '0;
        end else if (cnt_clr_i) begin
            r_retired <= '0;
        end else if (w_en) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired_o = r_retired;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a per-cycle vector table plus hand-written
// breakpoint and reset-mid-step sequences.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        run_i, step_i, halt_i, bp_en_i, cnt_clr_i;
    logic [7:0]  step_n_i;
    logic [8:0]  bp_addr_i;
    logic [8:0]  pc;
    logic        pc_rst;
    logic        en_o, bp_hit_o;
    logic [1:0]  state_o;
    logic [31:0] retired_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Bench-side datapath PC: advances by 4 for every retired instruction.
    always @(posedge clk) begin
        if (pc_rst)    pc <= 9'd0;
        else if (en_o) pc <= pc + 9'd4;
    end

    cpu_run_ctrl #(.PC_W(9), .STEP_W(8), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .run_i(run_i), .step_i(step_i), .halt_i(halt_i),
        .step_n_i(step_n_i), .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i), .pc_i(pc),
        .cnt_clr_i(cnt_clr_i), .en_o(en_o), .state_o(state_o), .bp_hit_o(bp_hit_o),
        .retired_o(retired_o)
    );

    typedef struct {
        logic        run, step, halt, clr;
        logic [7:0]  sn;
        logic        en;
        logic [1:0]  st;
        logic        hit;
        logic [31:0] ret;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic s, logic h, logic c, logic [7:0] n,
                                logic e, logic [1:0] st, logic hit, logic [31:0] ret);
        vec_t v;
        v.run = r; v.step = s; v.halt = h; v.clr = c; v.sn = n;
        v.en = e; v.st = st; v.hit = hit; v.ret = ret;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic h, input logic c,
                         input logic [7:0] n);
        @(negedge clk);
        run_i = r; step_i = s; halt_i = h; cnt_clr_i = c; step_n_i = n;
        #1;
    endtask

    task automatic chk3(input string nm, input logic e, input logic [1:0] st, input logic hit);
        chk({nm, ".en"}, {31'd0, en_o}, {31'd0, e});
        chk({nm, ".state"}, {30'd0, state_o}, {30'd0, st});
        chk({nm, ".bp_hit"}, {31'd0, bp_hit_o}, {31'd0, hit});
    endtask

    initial begin
        rst_i = 1'b0; run_i = 0; step_i = 0; halt_i = 0; cnt_clr_i = 0;
        step_n_i = 8'd0; bp_en_i = 0; bp_addr_i = 9'd0; pc_rst = 1'b1;

        // step 3, step 0 (treated as 1), run then simultaneous halt+step,
        // counter clear in HALT and in RUN, step press ignored while running.
        tbl.push_back(mk(0,1,0,0,8'd3, 0,2'd0,0,32'd0));
        tbl.push_back(mk(0,0,0,0,8'd3, 1,2'd2,0,32'd0));
        tbl.push_back(mk(0,0,0,0,8'd3, 1,2'd2,0,32'd1));
        tbl.push_back(mk(0,0,0,0,8'd3, 1,2'd2,0,32'd2));
        tbl.push_back(mk(0,0,0,0,8'd3, 0,2'd0,0,32'd3));
        tbl.push_back(mk(0,1,0,0,8'd0, 0,2'd0,0,32'd3));
        tbl.push_back(mk(0,0,0,0,8'd0, 1,2'd2,0,32'd3));
        tbl.push_back(mk(0,0,0,0,8'd0, 0,2'd0,0,32'd4));
        tbl.push_back(mk(1,0,0,0,8'd0, 0,2'd0,0,32'd4));
        tbl.push_back(mk(0,0,0,0,8'd0, 1,2'd1,0,32'd4));
        tbl.push_back(mk(0,0,0,0,8'd0, 1,2'd1,0,32'd5));
        tbl.push_back(mk(0,1,1,0,8'd0, 0,2'd1,0,32'd6));
        tbl.push_back(mk(0,0,0,0,8'd0, 0,2'd0,0,32'd6));
        tbl.push_back(mk(0,0,0,1,8'd0, 0,2'd0,0,32'd6));
        tbl.push_back(mk(0,0,0,0,8'd0, 0,2'd0,0,32'd0));
        tbl.push_back(mk(1,0,0,0,8'd0, 0,2'd0,0,32'd0));
        tbl.push_back(mk(0,0,0,0,8'd0, 1,2'd1,0,32'd0));
        tbl.push_back(mk(0,0,0,0,8'd0, 1,2'd1,0,32'd1));
        tbl.push_back(mk(0,0,0,0,8'd0, 1,2'd1,0,32'd2));
        tbl.push_back(mk(0,0,0,0,8'd0, 1,2'd1,0,32'd3));
        tbl.push_back(mk(0,0,0,0,8'd0, 1,2'd1,0,32'd4));
        tbl.push_back(mk(0,0,0,1,8'd0, 1,2'd1,0,32'd5));
        tbl.push_back(mk(0,0,0,0,8'd0, 1,2'd1,0,32'd0));
        tbl.push_back(mk(0,1,0,0,8'd0, 1,2'd1,0,32'd1));
        tbl.push_back(mk(0,0,0,0,8'd0, 1,2'd1,0,32'd2));
        tbl.push_back(mk(0,0,1,0,8'd0, 0,2'd1,0,32'd3));
        tbl.push_back(mk(0,0,0,0,8'd0, 0,2'd0,0,32'd3));

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        pc_rst = 1'b0;
        #1;
        chk3("reset", 1'b0, 2'd0, 1'b0);
        chk("reset.retired", retired_o, 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].run, tbl[i].step, tbl[i].halt, tbl[i].clr, tbl[i].sn);
            chk3($sformatf("vec%0d", i), tbl[i].en, tbl[i].st, tbl[i].hit);
            chk($sformatf("vec%0d.retired", i), retired_o, tbl[i].ret);
        end

        // Breakpoint at pc 12, then resume from the breakpoint without re-hitting.
        bp_en_i = 1'b1; bp_addr_i = 9'd12;
        @(negedge clk); pc_rst = 1'b1;
        @(negedge clk); pc_rst = 1'b0;
        drive(1,0,0,0,8'd0); chk3("bp.req", 0, 2'd0, 0);
        drive(0,0,0,0,8'd0); chk3("bp.pc0", 1, 2'd1, 0); chk("bp.pc0.pc", {23'd0, pc}, 32'd0);
        drive(0,0,0,0,8'd0); chk3("bp.pc4", 1, 2'd1, 0); chk("bp.pc4.pc", {23'd0, pc}, 32'd4);
        drive(0,0,0,0,8'd0); chk3("bp.pc8", 1, 2'd1, 0); chk("bp.pc8.pc", {23'd0, pc}, 32'd8);
        drive(0,0,0,0,8'd0); chk3("bp.hit", 0, 2'd1, 1); chk("bp.hit.pc", {23'd0, pc}, 32'd12);
        drive(0,0,0,0,8'd0); chk3("bp.brk", 0, 2'd3, 0); chk("bp.brk.pc", {23'd0, pc}, 32'd12);
        drive(1,0,0,0,8'd0); chk3("bp.resume_req", 0, 2'd3, 0);
        drive(0,0,0,0,8'd0); chk3("bp.pc12", 1, 2'd1, 0); chk("bp.pc12.pc", {23'd0, pc}, 32'd12);
        drive(0,0,0,0,8'd0); chk3("bp.pc16", 1, 2'd1, 0); chk("bp.pc16.pc", {23'd0, pc}, 32'd16);
        drive(0,0,1,0,8'd0); chk3("bp.halt", 0, 2'd1, 0);
        drive(0,0,0,0,8'd0); chk3("bp.halted", 0, 2'd0, 0);
        bp_en_i = 1'b0;

        // Reset while stepping with four steps still outstanding.
        drive(0,1,0,0,8'd6); chk3("rs.req", 0, 2'd0, 0);
        drive(0,0,0,0,8'd6); chk3("rs.s1", 1, 2'd2, 0);
        drive(0,0,0,0,8'd6); chk3("rs.s2", 1, 2'd2, 0);
        @(negedge clk); rst_i = 1'b0;
        @(negedge clk); #1;
        chk3("rs.after", 0, 2'd0, 0);
        chk("rs.after.retired", retired_o, 32'd0);
        rst_i = 1'b1;
        drive(0,0,0,0,8'd6); chk3("rs.idle", 0, 2'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
